// File: rtl/egg_timer_ctrl_if.sv
// Signal bundle between the button/tick front end and the egg timer sequencer.
// The adj_min pulse exists only when EGG_TIMER_ADJ_EN is defined.
interface egg_timer_ctrl_if;
  logic       start;
  logic       pause;
  logic       sec_tick;
`ifdef EGG_TIMER_ADJ_EN
  logic       adj_min;
`endif
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       alarm;

  modport master (
`ifdef EGG_TIMER_ADJ_EN
    output adj_min,
`endif
    output start, pause, sec_tick,
    input  min_bcd, sec_bcd, running, alarm
  );

  modport slave (
`ifdef EGG_TIMER_ADJ_EN
    input  adj_min,
`endif
    input  start, pause, sec_tick,
    output min_bcd, sec_bcd, running, alarm
  );
endinterface

// File: rtl/egg_timer_ctrl.sv
// BCD mm:ss countdown sequencer with start/pause/resume and a timed alarm phase.
// Optional feature macro EGG_TIMER_ADJ_EN adds in-IDLE minute adjustment.
module egg_timer_ctrl #(
  parameter int PRESET_MIN = 3,
  parameter int PRESET_SEC = 0,
  parameter int ALARM_SECS = 5
) (
  input  logic             clk,
  input  logic             rst,
  egg_timer_ctrl_if.slave  bus
);

  localparam logic [7:0] PRESET_MIN_BCD = {4'(PRESET_MIN / 10), 4'(PRESET_MIN % 10)};
  localparam logic [7:0] PRESET_SEC_BCD = {4'(PRESET_SEC / 10), 4'(PRESET_SEC % 10)};
  localparam logic [7:0] ALARM_INIT     = 8'(ALARM_SECS);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_ALARM} state_t;

  state_t     state, state_nxt;
  logic [7:0] min_q, min_nxt;
  logic [7:0] sec_q, sec_nxt;
  logic [7:0] cnt_q, cnt_nxt;
  logic [7:0] reload_min;
  logic       time_zero;

  // 00 wraps to 99; otherwise borrow from tens when units are 0.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00)         return 8'h99;
    else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                     return {v[7:4], v[3:0] - 4'd1};
  endfunction

`ifdef EGG_TIMER_ADJ_EN
  logic [7:0] reload_q, reload_nxt;
  assign reload_min = reload_q;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction
`else
  assign reload_min = PRESET_MIN_BCD;
`endif

  assign time_zero = (min_q == 8'h00) && (sec_q == 8'h00);

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      min_q <= PRESET_MIN_BCD;
      sec_q <= PRESET_SEC_BCD;
      cnt_q <= 8'd0;
`ifdef EGG_TIMER_ADJ_EN
      reload_q <= PRESET_MIN_BCD;
`endif
    end else begin
      state <= state_nxt;
      min_q <= min_nxt;
      sec_q <= sec_nxt;
      cnt_q <= cnt_nxt;
`ifdef EGG_TIMER_ADJ_EN
      reload_q <= reload_nxt;
`endif
    end
  end

  // NOTE: every next value defaults to the current value first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    min_nxt   = min_q;
    sec_nxt   = sec_q;
    cnt_nxt   = cnt_q;
`ifdef EGG_TIMER_ADJ_EN
    reload_nxt = reload_q;
`endif
    unique case (state)
      ST_IDLE: begin
        if (bus.start && !time_zero) begin
          state_nxt = ST_RUN;
`ifdef EGG_TIMER_ADJ_EN
        end else if (bus.adj_min) begin
          min_nxt    = bcd_inc(min_q);
          reload_nxt = bcd_inc(min_q);
`endif
        end
      end
      ST_RUN: begin
        if (bus.sec_tick) begin
          if (min_q == 8'h00 && sec_q == 8'h01) begin
            sec_nxt   = 8'h00;
            cnt_nxt   = ALARM_INIT;
            state_nxt = ST_ALARM;
          end else begin
            if (sec_q == 8'h00) begin
              sec_nxt = 8'h59;
              min_nxt = bcd_dec(min_q);
            end else begin
              sec_nxt = bcd_dec(sec_q);
            end
            if (bus.pause) state_nxt = ST_PAUSE;
          end
        end else if (bus.pause) begin
          state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (bus.start) state_nxt = ST_RUN;
      end
      ST_ALARM: begin
        if (bus.start || (bus.sec_tick && cnt_q == 8'd1)) begin
          state_nxt = ST_IDLE;
          min_nxt   = reload_min;
          sec_nxt   = PRESET_SEC_BCD;
          cnt_nxt   = 8'd0;
        end else if (bus.sec_tick) begin
          cnt_nxt = cnt_q - 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode registers only; no input reaches them combinationally.
  always_comb begin
    bus.min_bcd = min_q;
    bus.sec_bcd = sec_q;
    bus.running = (state == ST_RUN);
    bus.alarm   = (state == ST_ALARM);
  end

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Directed bench for egg_timer_ctrl: several parameterised instances share one stimulus stream.
// Build with EGG_TIMER_ADJ_EN defined to also exercise minute adjustment.
module tb_egg_timer_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, pause = 1'b0, sec_tick = 1'b0;
`ifdef EGG_TIMER_ADJ_EN
  logic adj_min = 1'b0;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  egg_timer_ctrl_if if_def ();
  egg_timer_ctrl_if if_cnt ();
  egg_timer_ctrl_if if_min ();
  egg_timer_ctrl_if if_alm ();
  egg_timer_ctrl_if if_zro ();

  assign if_def.start = start; assign if_def.pause = pause; assign if_def.sec_tick = sec_tick;
  assign if_cnt.start = start; assign if_cnt.pause = pause; assign if_cnt.sec_tick = sec_tick;
  assign if_min.start = start; assign if_min.pause = pause; assign if_min.sec_tick = sec_tick;
  assign if_alm.start = start; assign if_alm.pause = pause; assign if_alm.sec_tick = sec_tick;
  assign if_zro.start = start; assign if_zro.pause = pause; assign if_zro.sec_tick = sec_tick;
`ifdef EGG_TIMER_ADJ_EN
  assign if_def.adj_min = adj_min; assign if_cnt.adj_min = adj_min; assign if_min.adj_min = adj_min;
  assign if_alm.adj_min = adj_min; assign if_zro.adj_min = adj_min;
`endif

  egg_timer_ctrl #(.PRESET_MIN(3), .PRESET_SEC(0),  .ALARM_SECS(5)) u_def (.clk(clk), .rst(rst), .bus(if_def.slave));
  egg_timer_ctrl #(.PRESET_MIN(0), .PRESET_SEC(12), .ALARM_SECS(5)) u_cnt (.clk(clk), .rst(rst), .bus(if_cnt.slave));
  egg_timer_ctrl #(.PRESET_MIN(1), .PRESET_SEC(0),  .ALARM_SECS(5)) u_min (.clk(clk), .rst(rst), .bus(if_min.slave));
  egg_timer_ctrl #(.PRESET_MIN(0), .PRESET_SEC(2),  .ALARM_SECS(3)) u_alm (.clk(clk), .rst(rst), .bus(if_alm.slave));
  egg_timer_ctrl #(.PRESET_MIN(0), .PRESET_SEC(0),  .ALARM_SECS(5)) u_zro (.clk(clk), .rst(rst), .bus(if_zro.slave));

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1; step(); pause = 1'b0;
  endtask

  // Idle gap cycle, then a one-cycle tick, keeping ticks two clocks apart.
  task automatic do_tick();
    step();
    sec_tick = 1'b1; step(); sec_tick = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({if_def.min_bcd, if_def.sec_bcd, if_def.running, if_def.alarm} !== {8'h03, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_def got=%h exp=%h", {if_def.min_bcd, if_def.sec_bcd, if_def.running, if_def.alarm}, {8'h03, 8'h00, 1'b0, 1'b0});
    end
    do_start();
    total++;
    if ({if_zro.min_bcd, if_zro.sec_bcd, if_zro.running, if_zro.alarm} !== {8'h00, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL zero_start_ignored got=%h exp=%h", {if_zro.min_bcd, if_zro.sec_bcd, if_zro.running, if_zro.alarm}, {8'h00, 8'h00, 1'b0, 1'b0});
    end
  endtask

  task automatic test_countdown();
    logic [7:0] exp_sec [3] = '{8'h11, 8'h10, 8'h09};
    do_reset();
    do_start();
    total++;
    if ({if_cnt.min_bcd, if_cnt.sec_bcd, if_cnt.running} !== {8'h00, 8'h12, 1'b1}) begin
      bad++;
      $display("FAIL count_start got=%h exp=%h", {if_cnt.min_bcd, if_cnt.sec_bcd, if_cnt.running}, {8'h00, 8'h12, 1'b1});
    end
    for (int i = 0; i < 3; i++) begin
      do_tick();
      total++;
      if (if_cnt.sec_bcd !== exp_sec[i]) begin
        bad++;
        $display("FAIL count_tick%0d got=%h exp=%h", i, if_cnt.sec_bcd, exp_sec[i]);
      end
    end
    total++;
    if ({if_min.min_bcd, if_min.sec_bcd} !== {8'h00, 8'h57}) begin
      bad++;
      $display("FAIL min_borrow_chain got=%h exp=%h", {if_min.min_bcd, if_min.sec_bcd}, {8'h00, 8'h57});
    end
    rst = 1'b1; step(); rst = 1'b0;
    total++;
    if ({if_cnt.min_bcd, if_cnt.sec_bcd, if_cnt.running, if_cnt.alarm} !== {8'h00, 8'h12, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rst_mid_run got=%h exp=%h", {if_cnt.min_bcd, if_cnt.sec_bcd, if_cnt.running, if_cnt.alarm}, {8'h00, 8'h12, 1'b0, 1'b0});
    end
  endtask

  task automatic test_min_borrow();
    do_reset();
    do_start();
    do_tick();
    total++;
    if ({if_min.min_bcd, if_min.sec_bcd, if_min.running} !== {8'h00, 8'h59, 1'b1}) begin
      bad++;
      $display("FAIL min_borrow got=%h exp=%h", {if_min.min_bcd, if_min.sec_bcd, if_min.running}, {8'h00, 8'h59, 1'b1});
    end
  endtask

  task automatic test_pause();
    do_reset();
    do_start();
    do_tick(); do_tick();
    do_pause();
    for (int i = 0; i < 5; i++) do_tick();
    total++;
    if ({if_min.min_bcd, if_min.sec_bcd, if_min.running} !== {8'h00, 8'h58, 1'b0}) begin
      bad++;
      $display("FAIL pause_frozen got=%h exp=%h", {if_min.min_bcd, if_min.sec_bcd, if_min.running}, {8'h00, 8'h58, 1'b0});
    end
    do_start();
    do_tick();
    total++;
    if ({if_min.sec_bcd, if_min.running} !== {8'h57, 1'b1}) begin
      bad++;
      $display("FAIL resume_tick got=%h exp=%h", {if_min.sec_bcd, if_min.running}, {8'h57, 1'b1});
    end
    start = 1'b1; pause = 1'b1; step(); start = 1'b0; pause = 1'b0;
    total++;
    if ({if_min.sec_bcd, if_min.running} !== {8'h57, 1'b0}) begin
      bad++;
      $display("FAIL start_pause_run got=%h exp=%h", {if_min.sec_bcd, if_min.running}, {8'h57, 1'b0});
    end
    start = 1'b1; pause = 1'b1; step(); start = 1'b0; pause = 1'b0;
    total++;
    if (if_min.running !== 1'b1) begin
      bad++;
      $display("FAIL start_pause_paused got=%b exp=1", if_min.running);
    end
    step();
    sec_tick = 1'b1; pause = 1'b1; step(); sec_tick = 1'b0; pause = 1'b0;
    total++;
    if ({if_min.sec_bcd, if_min.running} !== {8'h56, 1'b0}) begin
      bad++;
      $display("FAIL tick_pause got=%h exp=%h", {if_min.sec_bcd, if_min.running}, {8'h56, 1'b0});
    end
  endtask

  task automatic test_alarm();
    do_reset();
    do_start();
    do_tick(); do_tick();
    total++;
    if ({if_alm.min_bcd, if_alm.sec_bcd, if_alm.running, if_alm.alarm} !== {8'h00, 8'h00, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL alarm_enter got=%h exp=%h", {if_alm.min_bcd, if_alm.sec_bcd, if_alm.running, if_alm.alarm}, {8'h00, 8'h00, 1'b0, 1'b1});
    end
    do_tick(); do_tick();
    total++;
    if (if_alm.alarm !== 1'b1) begin
      bad++;
      $display("FAIL alarm_hold got=%b exp=1", if_alm.alarm);
    end
    do_tick();
    total++;
    if ({if_alm.min_bcd, if_alm.sec_bcd, if_alm.running, if_alm.alarm} !== {8'h00, 8'h02, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL alarm_expire got=%h exp=%h", {if_alm.min_bcd, if_alm.sec_bcd, if_alm.running, if_alm.alarm}, {8'h00, 8'h02, 1'b0, 1'b0});
    end
    do_start();
    do_tick(); do_tick();
    do_start();
    total++;
    if ({if_alm.min_bcd, if_alm.sec_bcd, if_alm.running, if_alm.alarm} !== {8'h00, 8'h02, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL alarm_silence got=%h exp=%h", {if_alm.min_bcd, if_alm.sec_bcd, if_alm.running, if_alm.alarm}, {8'h00, 8'h02, 1'b0, 1'b0});
    end
    do_start();
    do_tick(); do_tick();
    do_reset();
    total++;
    if ({if_alm.min_bcd, if_alm.sec_bcd, if_alm.running, if_alm.alarm} !== {8'h00, 8'h02, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rst_mid_alarm got=%h exp=%h", {if_alm.min_bcd, if_alm.sec_bcd, if_alm.running, if_alm.alarm}, {8'h00, 8'h02, 1'b0, 1'b0});
    end
  endtask

`ifdef EGG_TIMER_ADJ_EN
  task automatic test_adjust();
    do_reset();
    for (int i = 0; i < 97; i++) begin
      adj_min = 1'b1; step(); adj_min = 1'b0; step();
    end
    total++;
    if ({if_def.min_bcd, if_def.sec_bcd} !== {8'h00, 8'h00}) begin
      bad++;
      $display("FAIL adj_wrap got=%h exp=%h", {if_def.min_bcd, if_def.sec_bcd}, {8'h00, 8'h00});
    end
    do_start();
    total++;
    if (if_def.running !== 1'b0) begin
      bad++;
      $display("FAIL adj_zero_start got=%b exp=0", if_def.running);
    end
    adj_min = 1'b1; step(); adj_min = 1'b0;
    total++;
    if (if_def.min_bcd !== 8'h01) begin
      bad++;
      $display("FAIL adj_one got=%h exp=01", if_def.min_bcd);
    end
    do_reset();
    total++;
    if (if_def.min_bcd !== 8'h03) begin
      bad++;
      $display("FAIL adj_rst got=%h exp=03", if_def.min_bcd);
    end
  endtask
`endif

  initial begin
    step();
    test_reset();
    test_countdown();
    test_min_borrow();
    test_pause();
    test_alarm();
`ifdef EGG_TIMER_ADJ_EN
    test_adjust();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
